// File: rtl/config_handshake_ctrl.sv
// UART link-configuration handshake sequencer between STR registers and TX/RX FIFOs.
// Optional retry/timeout logic is enabled by defining UART_CONFIG_TIMEOUT_EN.
module config_handshake_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_config_i,
  input  logic       send_config_req_i,
  input  logic       set_std_config_i,
  input  logic [5:0] req_cfg_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_write_o,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_cfg_frame_o,
  output logic       str_en_o,
  output logic [1:0] data_width_o,
  output logic [1:0] parity_mode_o,
  output logic [1:0] stop_bits_o,
  output logic       config_done_o,
  output logic       config_error_o
);

  // {SBID, PMID, DWID}: one stop bit, no parity, 8 data bits
  localparam logic [5:0] STD_CONFIGURATION = 6'b00_00_11;
  localparam logic [7:0] ACK_FRAME         = 8'h80;
  localparam logic [1:0] REQ_TAG           = 2'b01;

  if ((TIMEOUT_CYCLES == 0) || (MAX_RETRY > 32'h0000_FFFF)) begin : g_param_check
    $error("config_handshake_ctrl: TIMEOUT_CYCLES must be >= 1 and MAX_RETRY <= 65535");
  end

  typedef enum logic [2:0] {IDLE, SEND_REQ, WAIT_ACK, SEND_ACK, APPLY} state_t;

  state_t     state, state_nxt;
  logic [5:0] cfg_q, cfg_nxt;
  logic       ack_sent_q, ack_sent_nxt;
  logic [7:0] tx_data_nxt;
  logic       tx_write_nxt;
  logic       err_nxt;
  logic       ack_enter;
  logic       rx_is_req, rx_is_ack;

  assign rx_is_req = rx_valid_i && enable_config_i && (rx_data_i[7:6] == REQ_TAG);
  assign rx_is_ack = rx_valid_i && enable_config_i && (rx_data_i == ACK_FRAME);

  assign rx_cfg_frame_o = ((state == IDLE) && rx_is_req) ||
                          ((state == WAIT_ACK) && (rx_is_req || rx_is_ack));

`ifdef UART_CONFIG_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RTY_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic [RTY_W-1:0] retry_q;
  logic             tmo_clr, retry_clr, retry_inc;
  logic             timeout, retry_left;

  assign timeout    = (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES - 1));
  assign retry_left = (retry_q < RTY_W'(MAX_RETRY));

  // Saturating wait counter and retry counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      retry_q   <= '0;
    end else begin
      if (tmo_clr)
        tmo_cnt_q <= '0;
      else if ((state == WAIT_ACK) && (tmo_cnt_q != {TMO_W{1'b1}}))
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      if (retry_clr)
        retry_q <= '0;
      else if (retry_inc)
        retry_q <= retry_q + RTY_W'(1);
    end
  end
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_nxt    = state;
    cfg_nxt      = cfg_q;
    ack_sent_nxt = 1'b0;
    tx_data_nxt  = tx_data_o;
    tx_write_nxt = 1'b0;
    err_nxt      = config_error_o;
    ack_enter    = 1'b0;
`ifdef UART_CONFIG_TIMEOUT_EN
    tmo_clr      = 1'b0;
    retry_clr    = 1'b0;
    retry_inc    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_is_req) begin
          cfg_nxt   = rx_data_i[5:0];
          state_nxt = SEND_ACK;
          ack_enter = 1'b1;
        end else if (enable_config_i && (send_config_req_i || set_std_config_i)) begin
          cfg_nxt   = set_std_config_i ? STD_CONFIGURATION : req_cfg_i;
          err_nxt   = 1'b0;
          state_nxt = SEND_REQ;
`ifdef UART_CONFIG_TIMEOUT_EN
          retry_clr = 1'b1;
`endif
        end
      end
      SEND_REQ: begin
        if (tx_ready_i) begin
          tx_write_nxt = 1'b1;
          tx_data_nxt  = {REQ_TAG, cfg_q};
          state_nxt    = WAIT_ACK;
`ifdef UART_CONFIG_TIMEOUT_EN
          tmo_clr      = 1'b1;
`endif
        end
      end
      WAIT_ACK: begin
        if (rx_is_ack) begin
          state_nxt = APPLY;
        end else if (rx_is_req) begin
          err_nxt   = 1'b1;
          cfg_nxt   = rx_data_i[5:0];
          state_nxt = SEND_ACK;
          ack_enter = 1'b1;
        end
`ifdef UART_CONFIG_TIMEOUT_EN
        else if (timeout) begin
          if (retry_left) begin
            retry_inc = 1'b1;
            state_nxt = SEND_REQ;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
`endif
      end
      SEND_ACK: begin
        if (ack_sent_q) begin
          state_nxt = APPLY;
        end else if (tx_ready_i) begin
          tx_write_nxt = 1'b1;
          tx_data_nxt  = ACK_FRAME;
          state_nxt    = APPLY;
        end
      end
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The ACK goes out on entry to SEND_ACK when the FIFO is already ready
    if (ack_enter && tx_ready_i) begin
      tx_write_nxt = 1'b1;
      tx_data_nxt  = ACK_FRAME;
      ack_sent_nxt = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cfg_q          <= STD_CONFIGURATION;
      ack_sent_q     <= 1'b0;
      tx_data_o      <= '0;
      tx_write_o     <= 1'b0;
      str_en_o       <= 1'b0;
      data_width_o   <= STD_CONFIGURATION[1:0];
      parity_mode_o  <= STD_CONFIGURATION[3:2];
      stop_bits_o    <= STD_CONFIGURATION[5:4];
      config_done_o  <= 1'b1;
      config_error_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      cfg_q          <= cfg_nxt;
      ack_sent_q     <= ack_sent_nxt;
      tx_data_o      <= tx_data_nxt;
      tx_write_o     <= tx_write_nxt;
      str_en_o       <= (state_nxt == APPLY);
      config_done_o  <= (state_nxt == IDLE);
      config_error_o <= err_nxt;
      if (state_nxt == APPLY) begin
        data_width_o  <= cfg_q[1:0];
        parity_mode_o <= cfg_q[3:2];
        stop_bits_o   <= cfg_q[5:4];
      end
    end
  end

endmodule

// File: tb/tb_config_handshake_ctrl.sv
// Scoreboard bench for config_handshake_ctrl: stimulus pushes expected TX bytes and STR
// commits into a queue; a monitor pops and compares on every tx_write_o / str_en_o.
module tb_config_handshake_ctrl;

  localparam int unsigned T_CYC = 16;
  localparam int unsigned M_RTY = 2;
  localparam logic [5:0]  STD_CFG = 6'b00_00_11;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_config_i = 1'b1;
  logic       send_config_req_i = 1'b0;
  logic       set_std_config_i = 1'b0;
  logic [5:0] req_cfg_i = '0;
  logic       tx_ready_i = 1'b1;
  logic [7:0] tx_data_o;
  logic       tx_write_o;
  logic [7:0] rx_data_i = '0;
  logic       rx_valid_i = 1'b0;
  logic       rx_cfg_frame_o;
  logic       str_en_o;
  logic [1:0] data_width_o, parity_mode_o, stop_bits_o;
  logic       config_done_o, config_error_o;

  config_handshake_ctrl #(.TIMEOUT_CYCLES(T_CYC), .MAX_RETRY(M_RTY)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_config_i(enable_config_i),
    .send_config_req_i(send_config_req_i), .set_std_config_i(set_std_config_i),
    .req_cfg_i(req_cfg_i), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
    .tx_write_o(tx_write_o), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_cfg_frame_o(rx_cfg_frame_o), .str_en_o(str_en_o), .data_width_o(data_width_o),
    .parity_mode_o(parity_mode_o), .stop_bits_o(stop_bits_o),
    .config_done_o(config_done_o), .config_error_o(config_error_o)
  );

  always #5 clk = ~clk;

  logic [8:0] sb_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  bit  exp_err = 1'b0;
  bit  stall_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] req_frame(input logic [5:0] cfg);
    return {2'b01, cfg};
  endfunction
  function automatic logic [8:0] ev_tx(input logic [7:0] b);
    return {1'b0, b};
  endfunction
  function automatic logic [8:0] ev_str(input logic [5:0] cfg);
    return {1'b1, 2'b00, cfg};
  endfunction

  // Monitor: every TX write and every STR commit must match the queue head
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (tx_write_o) begin
          if (sb_q.size() == 0) chk("unexpected_tx", {1'b0, tx_data_o}, 9'h1FF);
          else begin e = sb_q.pop_front(); chk("sb_event", ev_tx(tx_data_o), e); end
        end
        if (str_en_o) begin
          if (sb_q.size() == 0) chk("unexpected_str", {3'b100, stop_bits_o, parity_mode_o, data_width_o}, 9'h1FF);
          else begin
            e = sb_q.pop_front();
            chk("sb_event", ev_str({stop_bits_o, parity_mode_o, data_width_o}), e);
          end
        end
      end
    end
  end

  // Optional random back-pressure on the TX FIFO
  initial forever begin
    @(posedge clk); #1;
    tx_ready_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_write(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = tx_write_o;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = config_done_o;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic local_req(input logic [5:0] cfg, input bit std);
    sb_q.push_back(ev_tx(req_frame(std ? STD_CFG : cfg)));
    exp_err = 1'b0;
    req_cfg_i = cfg;
    if (std) set_std_config_i = 1'b1; else send_config_req_i = 1'b1;
    tick();
    send_config_req_i = 1'b0;
    set_std_config_i  = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, output logic consumed);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    #1 consumed = rx_cfg_frame_o;
    tick();
    rx_valid_i = 1'b0;
  endtask

  initial begin
    logic       c;
    logic [5:0] ca, cb;
    logic [7:0] b;
    bit         std;
    int         wr_at[$];

    #12;
    chk("rst_tx_write", tx_write_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_str_en", str_en_o, 0);
    chk("rst_done", config_done_o, 1);
    chk("rst_error", config_error_o, 0);
    chk("rst_std_cfg", {stop_bits_o, parity_mode_o, data_width_o}, STD_CFG);
    @(posedge clk); #1 rst_i = 1'b0;
    tick();

    // Local request, ACK 10 cycles after the send
    local_req(6'b01_10_11, 1'b0);
    @(negedge clk) chk("lat_n1_no_write", tx_write_o, 0);
    tick();
    @(negedge clk);
    chk("lat_n2_write", tx_write_o, 1);
    chk("req_frame_5b", tx_data_o, 8'h5B);
    repeat (10) tick();
    sb_q.push_back(ev_str(6'b01_10_11));
    send_rx(8'h80, c);
    chk("ack_consumed", c, 1);
    @(negedge clk);
    chk("ack_str_en", str_en_o, 1);
    chk("ack_cfg", {stop_bits_o, parity_mode_o, data_width_o}, 6'b01_10_11);
    chk("ack_done_low", config_done_o, 0);
    tick();
    @(negedge clk);
    chk("ack_done_back", config_done_o, 1);
    chk("ack_str_once", str_en_o, 0);

    // Remote frame 8'h46 in IDLE
    tick();
    sb_q.push_back(ev_tx(8'h80));
    sb_q.push_back(ev_str(6'b00_01_10));
    send_rx(8'h46, c);
    chk("remote_consumed", c, 1);
    @(negedge clk);
    chk("remote_ack_write", tx_write_o, 1);
    chk("remote_ack_data", tx_data_o, 8'h80);
    tick();
    @(negedge clk);
    chk("remote_str_en", str_en_o, 1);
    chk("remote_cfg", {stop_bits_o, parity_mode_o, data_width_o}, 6'b00_01_10);
    wait_idle("remote_idle");

    // Stray ACK and non-config bytes in IDLE pass through
    tick();
    send_rx(8'h80, c);
    chk("stray_ack_pass", c, 0);
    b = 8'($urandom);
    if (b[7:6] == 2'b01) b[7:6] = 2'b11;
    send_rx(b, c);
    chk("stray_byte_pass", c, 0);
    repeat (3) tick();
    chk("stray_still_idle", config_done_o, 1);

    // Disabled: neither frame nor request starts a handshake
    enable_config_i = 1'b0;
    send_config_req_i = 1'b1;
    req_cfg_i = 6'h2A;
    send_rx(8'h46, c);
    send_config_req_i = 1'b0;
    chk("disabled_pass", c, 0);
    repeat (5) tick();
    chk("disabled_idle", config_done_o, 1);
    enable_config_i = 1'b1;

    // Randomized mix with TX back-pressure
    stall_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      tick();
      case ($urandom_range(0, 3))
        0: begin
          ca  = 6'($urandom);
          std = ($urandom_range(0, 3) == 0);
          local_req(ca, std);
          wait_write("rnd_local_write");
          repeat ($urandom_range(1, 12)) tick();
          sb_q.push_back(ev_str(std ? STD_CFG : ca));
          send_rx(8'h80, c);
          chk("rnd_ack_consumed", c, 1);
          wait_idle("rnd_local_idle");
        end
        1: begin
          cb = 6'($urandom);
          sb_q.push_back(ev_tx(8'h80));
          sb_q.push_back(ev_str(cb));
          send_rx(req_frame(cb), c);
          chk("rnd_remote_consumed", c, 1);
          wait_idle("rnd_remote_idle");
        end
        2: begin
          ca = 6'($urandom);
          cb = 6'($urandom);
          local_req(ca, 1'b0);
          wait_write("rnd_coll_write");
          repeat ($urandom_range(1, 10)) tick();
          sb_q.push_back(ev_tx(8'h80));
          sb_q.push_back(ev_str(cb));
          exp_err = 1'b1;
          send_rx(req_frame(cb), c);
          chk("rnd_coll_consumed", c, 1);
          wait_idle("rnd_coll_idle");
        end
        default: begin
          b = 8'($urandom);
          if (b[7:6] == 2'b01) b = 8'h80;
          send_rx(b, c);
          chk("rnd_stray_pass", c, 0);
        end
      endcase
      @(negedge clk);
      chk("rnd_error_flag", config_error_o, 32'(exp_err));
    end
    stall_en = 1'b0;

    // Reset in WAIT_ACK aborts without an STR commit
    tick();
    local_req(6'h15, 1'b0);
    wait_write("rst_case_write");
    repeat (3) tick();
    rst_i = 1'b1;
    #1;
    chk("midrst_tx_write", tx_write_o, 0);
    chk("midrst_str_en", str_en_o, 0);
    chk("midrst_done", config_done_o, 1);
    chk("midrst_error", config_error_o, 0);
    chk("midrst_std_cfg", {stop_bits_o, parity_mode_o, data_width_o}, STD_CFG);
    tick();
    rst_i = 1'b0;
    exp_err = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", config_done_o, 1);

`ifdef UART_CONFIG_TIMEOUT_EN
    // No ACK: first attempt plus MAX_RETRY re-sends, then failure
    for (int i = 0; i <= int'(M_RTY); i++) sb_q.push_back(ev_tx(req_frame(6'h2D)));
    local_req(6'h2D, 1'b0);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_write_o) wr_at.push_back(i);
    end
    chk("tmo_write_count", wr_at.size(), M_RTY + 1);
    for (int i = 1; i < wr_at.size(); i++)
      chk("tmo_spacing", wr_at[i] - wr_at[i-1], T_CYC + 1);
    chk("tmo_idle", config_done_o, 1);
    chk("tmo_error", config_error_o, 1);

    // ACK on the timeout cycle wins
    tick();
    local_req(6'h09, 1'b0);
    wait_write("edge_write");
    repeat (T_CYC - 1) tick();
    sb_q.push_back(ev_str(6'h09));
    send_rx(8'h80, c);
    chk("edge_ack_consumed", c, 1);
    wait_idle("edge_idle");
    chk("edge_error_clear", config_error_o, 0);
`endif

    repeat (5) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
